// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera configuration sequencer and its helpers.
package cam_cfg_pkg;

    // ROM words with special meaning; every other word is a {reg_addr, reg_data} write.
    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        REQ,
        WAIT,
        DELAY,
        NEXT,
        DONE
    } state_t;

    // Counter width for a delay of 'cycles' clocks; never narrower than 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Loadable down-counter: load a value, count down while enabled, flag zero.
module cfg_delay_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over counting; the counter rests at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == '0);

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera config ROM and issues register writes to the SCCB master.
// SCCB handshake: a write transfers on a clock edge where o_sccb_valid and
// i_sccb_ready are both high; addr/data are held stable while valid waits for
// ready, and i_sccb_done (one cycle) reports that the accepted write finished.
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int CLK_F    = 25_000_000,
    parameter int DELAY_MS = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [7:0]  o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic        o_sccb_valid,
    input  logic        i_sccb_ready,
    output logic [7:0]  o_sccb_addr,
    output logic [7:0]  o_sccb_data,
    input  logic        i_sccb_done,
    output logic        o_busy,
    output logic        o_done,
    output state_t      o_dbg_state
);

    localparam int DLY_CYC = CLK_F / 1000 * DELAY_MS;
    localparam int CNT_W   = cnt_width(DLY_CYC);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(DLY_CYC - 1);

    state_t     state_q;
    logic [7:0] rom_addr_q;
    logic       sccb_valid_q;
    logic [7:0] sccb_addr_q;
    logic [7:0] sccb_data_q;
    logic       busy_q;
    logic       done_q;

    logic timer_load;
    logic timer_en;
    logic timer_expired;

    // The timer is armed while decoding a delay marker and runs only in DELAY.
    always_comb begin
        timer_load = (state_q == DECODE) && (i_rom_data == CFG_DELAY);
        timer_en   = (state_q == DELAY);
    end

    cfg_delay_timer #(
        .W(CNT_W)
    ) u_delay_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (timer_load),
        .i_load_val (DLY_LOAD),
        .i_en       (timer_en),
        .o_expired  (timer_expired)
    );

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            rom_addr_q   <= 8'h00;
            sccb_valid_q <= 1'b0;
            sccb_addr_q  <= 8'h00;
            sccb_data_q  <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        rom_addr_q <= 8'h00;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    // ROM output for rom_addr_q becomes valid after this cycle.
                    state_q <= DECODE;
                end
                DECODE: begin
                    if (i_rom_data == CFG_END) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (i_rom_data == CFG_DELAY) begin
                        state_q <= DELAY;
                    end else begin
                        sccb_addr_q  <= i_rom_data[15:8];
                        sccb_data_q  <= i_rom_data[7:0];
                        sccb_valid_q <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (i_sccb_ready) begin
                        sccb_valid_q <= 1'b0;
                        state_q      <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_sccb_done) begin
                        state_q <= NEXT;
                    end
                end
                DELAY: begin
                    if (timer_expired) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    // The last ROM slot ends the sequence instead of wrapping to 0.
                    if (rom_addr_q == 8'hFF) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        rom_addr_q <= rom_addr_q + 8'd1;
                        state_q    <= FETCH;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_rom_addr   = rom_addr_q;
    assign o_sccb_valid = sccb_valid_q;
    assign o_sccb_addr  = sccb_addr_q;
    assign o_sccb_data  = sccb_data_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_dbg_state  = state_q;

endmodule
